// File: rtl/aes_pkg.sv
// AES helpers shared by the iterative core and other AES blocks.
// Byte 0 of any 128-bit state or 32-bit word sits at the MSBs.
package aes_pkg;

  typedef enum logic [2:0] {
    NOKEY,
    EXPAND,
    READY,
    ROUND,
    OUT
  } core_state_e;

  function automatic int nr(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (a^2 * a^4 * ... * a^128), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] idx);
    logic [7:0] r;
    case (idx)
      6'd1:    r = 8'h01;
      6'd2:    r = 8'h02;
      6'd3:    r = 8'h04;
      6'd4:    r = 8'h08;
      6'd5:    r = 8'h10;
      6'd6:    r = 8'h20;
      6'd7:    r = 8'h40;
      6'd8:    r = 8'h80;
      6'd9:    r = 8'h1b;
      6'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  // SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
  function automatic logic [127:0] aes_round(
    input logic [127:0] s,
    input logic [127:0] rk,
    input logic         last
  );
    logic [7:0]   b [16];
    logic [127:0] t;
    for (int i = 0; i < 16; i++)
      b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = b[4*((c+r)%4)+r];
    if (!last)
      for (int c = 0; c < 4; c++)
        t[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
    return t ^ rk;
  endfunction

endpackage

// File: rtl/aes_key_word.sv
// Next key-schedule word: w[i] = w[i-Nk] ^ f(w[i-1]).
// f is RotWord/SubWord/Rcon, SubWord only, or identity.
module aes_key_word #(
  parameter int KEY_BITS = 128
) (
  input  logic [31:0] prev,
  input  logic [31:0] old,
  input  logic [5:0]  idx,
  output logic [31:0] word
);
  import aes_pkg::*;

  localparam int NK = KEY_BITS / 32;

  logic [5:0] rem;
  logic [5:0] quot;

  always_comb begin
    rem  = idx % 6'(NK);
    quot = idx / 6'(NK);
    word = old ^ prev;
    if (rem == 6'd0)
      word = old ^ sub_word(rot_word(prev))
                 ^ {rcon(quot), 24'h0};
    else if (NK == 8 && rem == 6'd4)
      word = old ^ sub_word(prev);
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encrypt core: one schedule word per cycle during
// key load, then one round per cycle per block under that key.
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [127:0]        din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [127:0]        dout,
  output logic                dout_valid,
  input  logic                dout_ready
);
  import aes_pkg::*;

  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr(KEY_BITS);
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 &&
      KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128/192/256");
  end

  core_state_e state_q, state_d;

  logic [31:0]  w [NW];
  logic [5:0]   widx;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [31:0]  new_word;
  logic [127:0] rk;
  logic [127:0] round_out;
  logic         key_hs;
  logic         din_hs;
  logic         last_word;
  logic         last_round;

  assign key_hs     = key_valid && key_ready;
  assign din_hs     = din_valid && din_ready;
  assign last_word  = widx == 6'(NW - 1);
  assign last_round = rnd == 4'(NR);

  assign rk = {w[{rnd, 2'b00}], w[{rnd, 2'b01}],
               w[{rnd, 2'b10}], w[{rnd, 2'b11}]};

  assign round_out = aes_round(st, rk, last_round);

  aes_key_word #(
    .KEY_BITS(KEY_BITS)
  ) u_key_word (
    .prev(w[widx - 6'd1]),
    .old (w[widx - 6'(NK)]),
    .idx (widx),
    .word(new_word)
  );

  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    din_ready = 1'b0;
    case (state_q)
      NOKEY: begin
        key_ready = 1'b1;
        if (key_valid) state_d = EXPAND;
      end
      EXPAND: begin
        if (last_word) state_d = READY;
      end
      READY: begin
        key_ready = 1'b1;
        din_ready = !key_valid;
        if (key_valid)      state_d = EXPAND;
        else if (din_valid) state_d = ROUND;
      end
      ROUND: begin
        if (last_round) state_d = OUT;
      end
      OUT: begin
        if (dout_ready) state_d = READY;
      end
      default: state_d = NOKEY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= NOKEY;
      widx       <= '0;
      rnd        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (key_hs)
        widx <= 6'(NK);
      else if (state_q == EXPAND && !last_word)
        widx <= widx + 6'd1;
      if (din_hs)
        rnd <= 4'd1;
      else if (state_q == ROUND && !last_round)
        rnd <= rnd + 4'd1;
      if (state_q == ROUND && last_round) begin
        dout       <= round_out;
        dout_valid <= 1'b1;
      end else if (state_q == OUT && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  // Schedule and round state need no reset; the FSM gates their use.
  always_ff @(posedge clk) begin
    if (key_hs) begin
      for (int k = 0; k < NK; k++)
        w[k] <= key_in[KEY_BITS-1-32*k -: 32];
    end else if (state_q == EXPAND) begin
      w[widx] <= new_word;
    end
    if (din_hs)
      st <= din ^ {w[0], w[1], w[2], w[3]};
    else if (state_q == ROUND)
      st <= round_out;
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core at 128/192/256-bit keys
// with a scoreboard of expected ciphertexts.
module tb_aes_iter_core;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] key_w [3];
  logic [127:0] din_w [3];
  logic [127:0] dout_w [3];
  logic [2:0]   key_valid, key_ready;
  logic [2:0]   din_valid, din_ready;
  logic [2:0]   dout_valid, dout_ready;

  always #5 clk = ~clk;

  aes_iter_core #(.KEY_BITS(128)) u128 (
    .clk(clk), .reset(reset),
    .key_in(key_w[0][127:0]),
    .key_valid(key_valid[0]), .key_ready(key_ready[0]),
    .din(din_w[0]),
    .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .dout(dout_w[0]),
    .dout_valid(dout_valid[0]), .dout_ready(dout_ready[0])
  );

  aes_iter_core #(.KEY_BITS(192)) u192 (
    .clk(clk), .reset(reset),
    .key_in(key_w[1][191:0]),
    .key_valid(key_valid[1]), .key_ready(key_ready[1]),
    .din(din_w[1]),
    .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .dout(dout_w[1]),
    .dout_valid(dout_valid[1]), .dout_ready(dout_ready[1])
  );

  aes_iter_core #(.KEY_BITS(256)) u256 (
    .clk(clk), .reset(reset),
    .key_in(key_w[2]),
    .key_valid(key_valid[2]), .key_ready(key_ready[2]),
    .din(din_w[2]),
    .din_valid(din_valid[2]), .din_ready(din_ready[2]),
    .dout(dout_w[2]),
    .dout_valid(dout_valid[2]), .dout_ready(dout_ready[2])
  );

  localparam logic [255:0] KEY_F  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_F   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_F   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_192 =
    256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY_256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    int           u;
    logic [127:0] ct;
  } exp_t;

  exp_t         sb [$];
  int           acc_q [$];
  logic [127:0] next_ct [3];
  int           vecs = 0;
  int           errs = 0;
  int           cyc = 0;
  int           kacc [3];
  int           bacc [3];
  bit           kpend [3];
  bit           pdv [3];
  bit           pdr [3];
  bit           pdin [3];
  logic [127:0] pdout [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nr_of(input int u);
    return 10 + 2 * u;
  endfunction

  // Handshake-level monitor; inputs only change at posedge+1.
  always @(negedge clk) begin
    if (reset) begin
      for (int u = 0; u < 3; u++) begin
        kpend[u] = 1'b0;
        pdv[u]   = 1'b0;
        pdr[u]   = 1'b0;
        pdin[u]  = 1'b0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (din_ready[u] && !pdin[u] && kpend[u]) begin
          kpend[u] = 1'b0;
          chk("expand_latency", 128'(cyc - kacc[u]),
              128'(4 * (nr_of(u) + 1) - (4 + 2 * u)));
        end
        if (key_valid[u] && key_ready[u]) begin
          kacc[u]  = cyc + 1;
          kpend[u] = 1'b1;
        end
        if (din_valid[u] && din_ready[u]) begin
          bacc[u] = cyc + 1;
          acc_q.push_back(cyc + 1);
          sb.push_back('{u, next_ct[u]});
        end
        if (dout_valid[u] && !pdv[u])
          chk("enc_latency", 128'(cyc - bacc[u]),
              128'(nr_of(u)));
        if (dout_valid[u] && pdv[u] && !pdr[u]) begin
          chk("dout_stable", dout_w[u], pdout[u]);
          chk("din_ready_in_out", 128'(din_ready[u]), 128'(0));
        end
        if (dout_valid[u] && dout_ready[u]) begin
          if (sb.size() == 0) begin
            chk("scoreboard_empty", 128'(0), 128'(1));
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ct_unit", 128'(u), 128'(e.u));
            chk("ciphertext", dout_w[u], e.ct);
          end
        end
        pdv[u]   = dout_valid[u];
        pdr[u]   = dout_ready[u];
        pdin[u]  = din_ready[u];
        pdout[u] = dout_w[u];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int u, input logic [255:0] k);
    bit seen = 1'b0;
    key_w[u]     = k;
    key_valid[u] = 1'b1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (key_ready[u]) seen = 1'b1;
    end
    tick();
    key_valid[u] = 1'b0;
    chk("key_accept_seen", 128'(seen), 128'(1));
  endtask

  task automatic wait_din_ready(input int u);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (din_ready[u]) seen = 1'b1;
    end
    tick();
    chk("din_ready_seen", 128'(seen), 128'(1));
  endtask

  task automatic send_block(
    input int           u,
    input logic [127:0] pt,
    input logic [127:0] ct
  );
    bit seen = 1'b0;
    next_ct[u]   = ct;
    din_w[u]     = pt;
    din_valid[u] = 1'b1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (din_ready[u]) seen = 1'b1;
    end
    tick();
    din_valid[u] = 1'b0;
    chk("block_accept_seen", 128'(seen), 128'(1));
  endtask

  task automatic take_block(input int u, input int hold);
    bit seen = 1'b0;
    dout_ready[u] = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (dout_valid[u]) seen = 1'b1;
    end
    chk("dout_valid_seen", 128'(seen), 128'(1));
    repeat (hold) tick();
    tick();
    dout_ready[u] = 1'b1;
    tick();
    dout_ready[u] = 1'b0;
    @(negedge clk);
    chk("dout_valid_drop", 128'(dout_valid[u]), 128'(0));
    tick();
  endtask

  task automatic check_idle_reset(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      chk("din_ready_nokey", 128'(din_ready[0]), 128'(0));
    end
    tick();
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_key_ready", 128'(key_ready[0]), 128'(1));
    chk("rst_din_ready", 128'(din_ready[0]), 128'(0));
    chk("rst_dout_valid", 128'(dout_valid[0]), 128'(0));
    chk("rst_dout", dout_w[0], 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int u = 0; u < 3; u++) begin
      key_w[u]   = '0;
      din_w[u]   = '0;
      next_ct[u] = '0;
      kacc[u]    = 0;
      bacc[u]    = 0;
    end
    key_valid  = '0;
    din_valid  = '0;
    dout_ready = '0;

    // Reset values on every instance.
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("reset_key_ready", 128'(key_ready[u]), 128'(1));
      chk("reset_din_ready", 128'(din_ready[u]), 128'(0));
      chk("reset_dout_valid", 128'(dout_valid[u]), 128'(0));
      chk("reset_dout", dout_w[u], 128'(0));
    end
    tick();
    reset = 1'b0;
    tick();

    // FIPS-197 appendix B vector, then 20 cycles of back-pressure.
    load_key(0, KEY_F);
    wait_din_ready(0);
    send_block(0, PT_F, CT_F);
    take_block(0, 20);

    // Three back-to-back blocks with dout_ready tied high.
    acc_q.delete();
    next_ct[0]    = CT_F;
    din_w[0]      = PT_F;
    din_valid[0]  = 1'b1;
    dout_ready[0] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (acc_q.size() >= 3) seen = 1'b1;
    end
    din_valid[0] = 1'b0;
    chk("b2b_three_accepts", 128'(seen), 128'(1));
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (sb.size() == 0 && !dout_valid[0]) seen = 1'b1;
    end
    dout_ready[0] = 1'b0;
    chk("b2b_drained", 128'(seen), 128'(1));
    if (acc_q.size() >= 3) begin
      chk("b2b_period_1", 128'(acc_q[1] - acc_q[0]), 128'(12));
      chk("b2b_period_2", 128'(acc_q[2] - acc_q[1]), 128'(12));
    end
    tick();

    // Re-key from READY with appendix C.1 key.
    load_key(0, KEY_128);
    wait_din_ready(0);
    send_block(0, PT_C, CT_128);
    take_block(0, 0);

    // Key and block offered together: key wins, block waits.
    key_w[0]     = KEY_F;
    key_valid[0] = 1'b1;
    din_w[0]     = PT_F;
    next_ct[0]   = CT_F;
    din_valid[0] = 1'b1;
    @(negedge clk);
    chk("simul_din_ready", 128'(din_ready[0]), 128'(0));
    chk("simul_key_ready", 128'(key_ready[0]), 128'(1));
    tick();
    key_valid[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (sb.size() == 1) seen = 1'b1;
    end
    din_valid[0] = 1'b0;
    chk("simul_block_accept", 128'(seen), 128'(1));
    take_block(0, 0);

    // AES-192 and AES-256 appendix C vectors.
    load_key(1, KEY_192);
    wait_din_ready(1);
    send_block(1, PT_C, CT_192);
    take_block(1, 3);
    load_key(2, KEY_256);
    wait_din_ready(2);
    send_block(2, PT_C, CT_256);
    take_block(2, 3);

    // Reset while in ROUND with r==5.
    send_block(0, PT_F, CT_F);
    repeat (4) tick();
    reset = 1'b1;
    check_reset_outputs();
    sb.delete();
    tick();
    reset = 1'b0;
    check_idle_reset(20);
    chk("rst_round_no_dout", 128'(dout_valid[0]), 128'(0));
    load_key(0, KEY_128);
    wait_din_ready(0);
    send_block(0, PT_C, CT_128);
    take_block(0, 0);

    // Reset in the middle of key expansion.
    load_key(0, KEY_F);
    repeat (10) tick();
    reset = 1'b1;
    check_reset_outputs();
    tick();
    reset = 1'b0;
    check_idle_reset(50);
    load_key(0, KEY_F);
    wait_din_ready(0);
    send_block(0, PT_F, CT_F);
    take_block(0, 0);

    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
